// File: rtl/spam_lcd_queued_if.sv
// SPAM request/acknowledge bundle between a SPAM master and the queued LCD slave.
// Widths must match the SPAM_*_HI parameters of the slave it is bound to.
interface spam_lcd_queued_if #(
    parameter int unsigned SPAM_DID_HI  = 3,
    parameter int unsigned SPAM_ADDR_HI = 15,
    parameter int unsigned SPAM_DATA_HI = 31
);
    logic                  spamo_valid;
    logic                  spamo_r_nw;
    logic [SPAM_DID_HI:0]  spamo_did;
    logic [SPAM_ADDR_HI:0] spamo_addr;
    logic [SPAM_DATA_HI:0] spamo_data;
    logic                  lcd__spami_busy_b;
    logic [SPAM_DATA_HI:0] lcd__spami_data;

    modport master (
        output spamo_valid,
        output spamo_r_nw,
        output spamo_did,
        output spamo_addr,
        output spamo_data,
        input  lcd__spami_busy_b,
        input  lcd__spami_data
    );

    modport slave (
        input  spamo_valid,
        input  spamo_r_nw,
        input  spamo_did,
        input  spamo_addr,
        input  spamo_data,
        output lcd__spami_busy_b,
        output lcd__spami_data
    );
endinterface

// File: rtl/spam_lcd_queued.sv
// SPAM slave driving an HD44780-class LCD: posted writes go through a FIFO drained by a
// setup/enable/hold timing engine; LCD reads wait for the queue to drain and run a sampled cycle.
module spam_lcd_queued #(
    parameter int unsigned          SPAM_DID_HI  = 3,
    parameter int unsigned          SPAM_ADDR_HI = 15,
    parameter int unsigned          SPAM_DATA_HI = 31,
    parameter int unsigned          SPAM_DID_LCD = 9,
    parameter logic [SPAM_DID_HI:0] DID          = (SPAM_DID_HI + 1)'(SPAM_DID_LCD),
    parameter int unsigned          DB_WIDTH     = 4,
    parameter int unsigned          FIFO_DEPTH   = 4,
    parameter int unsigned          T_SETUP      = 60,
    parameter int unsigned          T_ENABLE     = 90,
    parameter int unsigned          T_HOLD       = 40,
    parameter int unsigned          SAMPLE_AT    = 5
) (
    input  logic                clk,
    input  logic                rst_b,
    spam_lcd_queued_if.slave    bus,
    output logic [DB_WIDTH-1:0] lcd_db_o,
    output logic                lcd_db_oe,
    input  logic [DB_WIDTH-1:0] lcd_db_i,
    output logic                lcd_e,
    output logic                lcd_rnw,
    output logic                lcd_rs
);

    localparam int unsigned PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = DB_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StSetup, StEnable, StHold} state_e;

    state_e              state;
    logic [15:0]         cnt;
    logic                cyc_read;
    logic [DB_WIDTH-1:0] rd_sample;

    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       level;

    logic                wr_pend;
    logic                pend_rs;
    logic [DB_WIDTH-1:0] pend_db;
    logic                rd_pend;
    logic                rd_rs;

    logic                  ack;
    logic [SPAM_DATA_HI:0] ack_data;

    logic [SPAM_ADDR_HI:0] addr;
    logic [1:0]            sel;
    logic                  hit;
    logic                  req_lcd_wr;
    logic                  req_lcd_rd;
    logic                  req_local;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  wr_rs;
    logic [DB_WIDTH-1:0]   wr_db;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  grant;
    logic                  rd_done;
    logic [EW-1:0]         head;
    logic [SPAM_DATA_HI:0] status_word;
    logic [SPAM_DATA_HI:0] read_word;
    logic                  unused_bits;

    assign addr       = bus.spamo_addr;
    assign sel        = addr[3:2];
    assign hit        = bus.spamo_valid && (bus.spamo_did == DID);
    assign req_lcd_wr = hit && !bus.spamo_r_nw && !sel[1];
    assign req_lcd_rd = hit && bus.spamo_r_nw && !sel[1];
    assign req_local  = hit && sel[1];

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));

    // A write stalled on a full FIFO is replayed from the pending latch.
    assign wr_rs = wr_pend ? pend_rs : sel[0];
    assign wr_db = wr_pend ? pend_db : bus.spamo_data[DB_WIDTH-1:0];
    assign push  = (wr_pend || req_lcd_wr) && !fifo_full;
    assign flush = req_local && !bus.spamo_r_nw && sel[0] && bus.spamo_data[0];
    assign pop   = (state == StIdle) && !fifo_empty && !flush;
    assign grant = (state == StIdle) && fifo_empty && rd_pend;

    assign rd_done = (state == StHold) && (cnt == '0) && cyc_read;
    assign head    = mem[rd_ptr];

    always_comb begin
        status_word           = '0;
        status_word[18]       = (state != StIdle);
        status_word[17]       = fifo_full;
        status_word[16]       = fifo_empty;
        status_word[LW-1:0]   = level;
        read_word             = '0;
        read_word[DB_WIDTH-1:0] = rd_sample;
    end

    assign unused_bits = ^{addr, bus.spamo_data};

    assign bus.lcd__spami_busy_b = ack;
    assign bus.lcd__spami_data   = ack_data;

    // Bus side: acks, pending requests and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ack      <= 1'b0;
            ack_data <= '0;
            wr_pend  <= 1'b0;
            pend_rs  <= 1'b0;
            pend_db  <= '0;
            rd_pend  <= 1'b0;
            rd_rs    <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            ack      <= 1'b0;
            ack_data <= '0;

            if (push) begin
                wr_pend <= 1'b0;
                ack     <= 1'b1;
            end else if (req_lcd_wr) begin
                wr_pend <= 1'b1;
                pend_rs <= sel[0];
                pend_db <= bus.spamo_data[DB_WIDTH-1:0];
            end

            if (req_lcd_rd) begin
                rd_pend <= 1'b1;
                rd_rs   <= sel[0];
            end else if (grant) begin
                rd_pend <= 1'b0;
            end

            if (req_local) begin
                ack <= 1'b1;
                if (bus.spamo_r_nw && !sel[0]) begin
                    ack_data <= status_word;
                end
            end

            if (rd_done) begin
                ack      <= 1'b1;
                ack_data <= read_word;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   level <= level + 1'b1;
                    2'b01:   level <= level - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_rs, wr_db};
        end
    end

    // Timing engine; pins are latched on SETUP entry and held until the next one.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= StIdle;
            cnt       <= '0;
            cyc_read  <= 1'b0;
            rd_sample <= '0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rnw   <= 1'b0;
            lcd_db_o  <= '0;
            lcd_db_oe <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (pop) begin
                        state     <= StSetup;
                        cnt       <= 16'(T_SETUP);
                        cyc_read  <= 1'b0;
                        lcd_rs    <= head[DB_WIDTH];
                        lcd_db_o  <= head[DB_WIDTH-1:0];
                        lcd_rnw   <= 1'b0;
                        lcd_db_oe <= 1'b1;
                    end else if (grant) begin
                        state     <= StSetup;
                        cnt       <= 16'(T_SETUP);
                        cyc_read  <= 1'b1;
                        lcd_rs    <= rd_rs;
                        lcd_db_o  <= '0;
                        lcd_rnw   <= 1'b1;
                        lcd_db_oe <= 1'b0;
                    end
                end
                StSetup: begin
                    if (cnt == '0) begin
                        state <= StEnable;
                        cnt   <= 16'(T_ENABLE);
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StEnable: begin
                    if (cyc_read && (cnt == 16'(SAMPLE_AT))) begin
                        rd_sample <= lcd_db_i;
                    end
                    if (cnt == '0) begin
                        state <= StHold;
                        cnt   <= 16'(T_HOLD);
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StHold: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spam_lcd_queued.sv
// Directed bench for spam_lcd_queued: a default 4-bit instance and a fast 8-bit instance.
module tb_spam_lcd_queued;

    localparam logic [3:0] DID = 4'h9;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    spam_lcd_queued_if ia ();
    spam_lcd_queued_if ib ();

    logic [3:0] a_db_o, a_db_i;
    logic       a_oe, a_e, a_rnw, a_rs;
    logic [7:0] b_db_o, b_db_i;
    logic       b_oe, b_e, b_rnw, b_rs;

    int samp_a = -1;
    int samp_b = -1;
    assign a_db_i = (cyc == samp_a) ? 4'hA : 4'h5;
    assign b_db_i = (cyc == samp_b) ? 8'h3C : 8'hC3;

    spam_lcd_queued dut_a (
        .clk      (clk),
        .rst_b    (rst_b),
        .bus      (ia),
        .lcd_db_o (a_db_o),
        .lcd_db_oe(a_oe),
        .lcd_db_i (a_db_i),
        .lcd_e    (a_e),
        .lcd_rnw  (a_rnw),
        .lcd_rs   (a_rs)
    );

    spam_lcd_queued #(
        .DB_WIDTH (8),
        .T_SETUP  (2),
        .T_ENABLE (2),
        .T_HOLD   (2),
        .SAMPLE_AT(0)
    ) dut_b (
        .clk      (clk),
        .rst_b    (rst_b),
        .bus      (ib),
        .lcd_db_o (b_db_o),
        .lcd_db_oe(b_oe),
        .lcd_db_i (b_db_i),
        .lcd_e    (b_e),
        .lcd_rnw  (b_rnw),
        .lcd_rs   (b_rs)
    );

    // Log every lcd_e rising edge of instance A as {rnw, oe, rs, db}.
    int         rise_cyc[$];
    logic [6:0] rise_val[$];
    logic       e_prev = 1'b0;
    always @(negedge clk) begin
        if (a_e && !e_prev) begin
            rise_cyc.push_back(cyc);
            rise_val.push_back({a_rnw, a_oe, a_rs, a_db_o});
            if (a_rnw) samp_a = cyc + 85;
        end
        e_prev = a_e;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req_a(input logic rnw, input logic [15:0] addr, input logic [31:0] wd,
                         input int budget, output logic [31:0] rd, output int lat);
        ia.spamo_valid = 1'b1;
        ia.spamo_r_nw  = rnw;
        ia.spamo_did   = DID;
        ia.spamo_addr  = addr;
        ia.spamo_data  = wd;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            ia.spamo_valid = 1'b0;
            lat++;
        end while (!ia.lcd__spami_busy_b && lat < budget);
        rd = ia.lcd__spami_data;
    endtask

    task automatic req_b(input logic rnw, input logic [15:0] addr, input logic [31:0] wd,
                         input int budget, output logic [31:0] rd, output int lat);
        ib.spamo_valid = 1'b1;
        ib.spamo_r_nw  = rnw;
        ib.spamo_did   = DID;
        ib.spamo_addr  = addr;
        ib.spamo_data  = wd;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            ib.spamo_valid = 1'b0;
            lat++;
        end while (!ib.lcd__spami_busy_b && lat < budget);
        rd = ib.lcd__spami_data;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          n, base;

        ia.spamo_valid = 1'b0; ia.spamo_r_nw = 1'b0; ia.spamo_did = '0;
        ia.spamo_addr  = '0;   ia.spamo_data = '0;
        ib.spamo_valid = 1'b0; ib.spamo_r_nw = 1'b0; ib.spamo_did = '0;
        ib.spamo_addr  = '0;   ib.spamo_data = '0;

        // Reset values
        step(3);
        chk("rst_outs_a", {ia.lcd__spami_busy_b, ia.lcd__spami_data, a_e, a_rs, a_rnw, a_db_o, a_oe},
            64'h0);
        chk("rst_outs_b", {ib.lcd__spami_busy_b, ib.lcd__spami_data, b_e, b_rs, b_rnw, b_db_o, b_oe},
            64'h0);
        rst_b = 1'b1;
        step(2);
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("rst_status", rd, 32'h0001_0000);
        step(1);

        // Single command write 0x28: full timing of one engine cycle
        n = cyc;
        req_a(1'b0, 16'h0, 32'h28, 8, rd, lat);
        chk("t1_ack_lat", lat, 1);
        step(1);
        chk("t1_ack_pulse", ia.lcd__spami_busy_b, 1'b0);
        chk("t1_setup_pins", {a_rs, a_rnw, a_oe, a_e, a_db_o}, {1'b0, 1'b0, 1'b1, 1'b0, 4'h8});
        wait_to(n + 62);
        chk("t1_e_before", a_e, 1'b0);
        step(1);
        chk("t1_e_first", a_e, 1'b1);
        wait_to(n + 153);
        chk("t1_e_last", a_e, 1'b1);
        step(1);
        chk("t1_e_after", a_e, 1'b0);
        wait_to(n + 194);
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t1_busy_hold", rd, 32'h0005_0000);
        step(1);
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t1_idle", rd, 32'h0001_0000);
        step(1);

        // Six back-to-back writes; the sixth stalls on the full FIFO
        base = rise_cyc.size();
        n = cyc;
        for (int k = 0; k < 6; k++) begin
            req_a(1'b0, (k % 2 == 1) ? 16'h4 : 16'h0, 32'h21 + k, 400, rd, lat);
            chk($sformatf("t2_lat%0d", k), lat, (k < 5) ? 1 : 187);
            step(1);
        end
        wait_to(n + 1170);
        chk("t2_count", rise_cyc.size(), base + 6);
        chk("t2_first_rise", rise_cyc[base], n + 63);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_val%0d", k), rise_val[base + k],
                {1'b0, 1'b1, (k % 2 == 1) ? 1'b1 : 1'b0, 4'(k + 1)});
            if (k > 0) chk($sformatf("t2_gap%0d", k), rise_cyc[base + k] - rise_cyc[base + k - 1], 194);
        end

        // LCD read waits behind two queued writes
        base = rise_cyc.size();
        n = cyc;
        req_a(1'b0, 16'h0, 32'h37, 8, rd, lat);
        step(1);
        req_a(1'b0, 16'h4, 32'h3B, 8, rd, lat);
        step(1);
        req_a(1'b1, 16'h4, 32'h0, 700, rd, lat);
        chk("t3_rd_lat", lat, 579);
        chk("t3_rd_data", rd, 32'h0000_000A);
        chk("t3_rd_rise", rise_cyc[base + 2], n + 451);
        chk("t3_rd_pins", rise_val[base + 2], {1'b1, 1'b0, 1'b1, 4'h0});
        step(1);

        // Status with queued entries, then flush
        base = rise_cyc.size();
        n = cyc;
        for (int k = 0; k < 3; k++) begin
            req_a(1'b0, 16'h4, 32'h41 + k, 8, rd, lat);
            step(1);
        end
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t4_status_q", rd, 32'h0004_0002);
        step(1);
        req_a(1'b0, 16'hC, 32'h1, 8, rd, lat);
        chk("t4_flush_lat", lat, 1);
        chk("t4_flush_data", rd, 32'h0);
        step(1);
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t4_status_flushed", rd, 32'h0005_0000);
        step(1);
        req_a(1'b1, 16'hC, 32'h0, 8, rd, lat);
        chk("t4_ctrl_read", rd, 32'h0);
        wait_to(n + 700);
        chk("t4_pulses", rise_cyc.size(), base + 1);
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t4_status_end", rd, 32'h0001_0000);
        step(1);

        // 8-bit fast instance: 9-cycle engine period
        n = cyc;
        req_b(1'b0, 16'h4, 32'hA5, 8, rd, lat);
        chk("t5_ack_lat", lat, 1);
        step(1);
        chk("t5_setup_pins", {b_rs, b_rnw, b_oe, b_e, b_db_o}, {1'b1, 1'b0, 1'b1, 1'b0, 8'hA5});
        wait_to(n + 4);
        chk("t5_e_before", b_e, 1'b0);
        step(1);
        chk("t5_e_first", b_e, 1'b1);
        step(2);
        chk("t5_e_last", b_e, 1'b1);
        step(1);
        chk("t5_e_after", b_e, 1'b0);
        wait_to(n + 10);
        req_b(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t5_busy_hold", rd, 32'h0005_0000);
        step(1);
        req_b(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t5_idle", rd, 32'h0001_0000);
        step(1);
        samp_b = cyc + 7;
        req_b(1'b1, 16'h0, 32'h0, 40, rd, lat);
        chk("t5_rd_lat", lat, 11);
        chk("t5_rd_data", rd, 32'h0000_003C);
        step(1);

        // Asynchronous reset during ENABLE with two entries queued
        n = cyc;
        for (int k = 0; k < 3; k++) begin
            req_a(1'b0, 16'h4, 32'h51 + k, 8, rd, lat);
            step(1);
        end
        wait_to(n + 100);
        chk("t6_e_mid", a_e, 1'b1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("t6_e_async", a_e, 1'b0);
        chk("t6_outs", {ia.lcd__spami_busy_b, ia.lcd__spami_data, a_e, a_rs, a_rnw, a_db_o, a_oe},
            64'h0);
        step(2);
        rst_b = 1'b1;
        step(2);
        chk("t6_outs_after", {ia.lcd__spami_busy_b, ia.lcd__spami_data, a_e, a_rs, a_rnw, a_db_o, a_oe},
            64'h0);
        base = rise_cyc.size();
        req_a(1'b1, 16'h8, 32'h0, 8, rd, lat);
        chk("t6_status", rd, 32'h0001_0000);
        step(500);
        chk("t6_no_cycles", rise_cyc.size(), base);
        chk("t6_e_idle", a_e, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spam_lcd_queued.md
# spam_lcd_queued

Parametrised SPAM-bus slave that drives an HD44780-class character LCD in 4-bit or 8-bit bus mode. Writes are posted into a FIFO and acknowledged right away, and a timing engine drains the FIFO using configurable setup, enable and hold intervals. LCD reads run a real sampled read cycle. A local status/control register exposes the queue state and allows a flush. The block sits on the SPAM fabric alongside the other SPAM peripherals and replaces the single-transaction blocking LCD slave.

## Interface
- DID, default SPAM_DID_LCD: device ID that this slave decodes.
- DB_WIDTH, default 4: LCD data bus width; only 4 or 8 are legal.
- FIFO_DEPTH, default 4: posted-write depth; must be a power of two, 2..128.
- T_SETUP, default 60: setup interval; the SETUP state lasts T_SETUP+1 cycles.
- T_ENABLE, default 90: enable interval; lcd_e is high for T_ENABLE+1 cycles.
- T_HOLD, default 40: hold interval; the HOLD state lasts T_HOLD+1 cycles.
- SAMPLE_AT, default 5: ENABLE counter value at which lcd_db_i is captured; must be ≤ T_ENABLE.
- All T_* parameters are ≤ 65535. The counter is 16 bits.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- spamo_valid  in  1  single-cycle request strobe.
- spamo_r_nw  in  1  1 = read, 0 = write.
- spamo_did  in  SPAM_DID_HI+1  device ID.
- spamo_addr  in  SPAM_ADDR_HI+1  register address; bits [3:2] are decoded.
- spamo_data  in  SPAM_DATA_HI+1  write data.
- lcd__spami_busy_b  out  1  single-cycle acknowledge pulse.
- lcd__spami_data  out  SPAM_DATA_HI+1  read data; valid only while the ack is high, 0 otherwise.
- lcd_db_o  out  DB_WIDTH  LCD data driven out.
- lcd_db_oe  out  1  pad output enable; equals !lcd_rnw.
- lcd_db_i  in  DB_WIDTH  LCD data read back from the pads.
- lcd_e  out  1  LCD enable strobe.
- lcd_rnw  out  1  LCD read/not-write.
- lcd_rs  out  1  LCD register select.

## Operation
- A request is decoded when spamo_valid && spamo_did==DID.
- Each decoded request gets exactly one ack pulse.
- The master issues no further request to DID until that ack arrives.
- Address map, by addr[3:2]:
  - 0: LCD command (rs=0).
  - 1: LCD data (rs=1).
  - 2: status register.
  - 3: control register.
- Write to 0 or 1:
  - Push {rs, spamo_data[DB_WIDTH-1:0]} into the FIFO, then ack.
  - If the FIFO is full, latch the request and push/ack on the first cycle in which level<FIFO_DEPTH.
  - A pop in the same cycle does not free the slot for that cycle.
- Read of 0 or 1:
  - Latch the request and wait until the FIFO is empty and the engine is IDLE, preserving write→read order.
  - Run one engine cycle with lcd_rnw=1.
  - Capture lcd_db_i on the ENABLE cycle where the counter equals SAMPLE_AT.
  - Ack with the data zero-extended.
- Status read:
  - Ack with bit 18 = engine not IDLE, bit 17 = full, bit 16 = empty, bits [7:0] = level.
  - All other bits are 0.
- Control write:
  - data[0]=1 empties the FIFO; an engine cycle already in progress completes.
  - Ack.
- Control read: ack with data 0.
- Engine FSM, states IDLE, SETUP, ENABLE, HOLD:
  - IDLE → SETUP when a FIFO entry is popped, or when a pending LCD read is granted.
  - On that transition, lcd_rs, lcd_rnw, lcd_db_o and lcd_db_oe are registered. They hold until the next SETUP entry.
  - SETUP: counter runs T_SETUP→0, then → ENABLE.
  - ENABLE: lcd_e=1; counter runs T_ENABLE→0, then → HOLD.
  - HOLD: counter runs T_HOLD→0, then → IDLE. For a read cycle, the ack is issued on the transition to IDLE.
  - Writes drained from the FIFO produce no ack at the end of the engine cycle.
- The FIFO has priority over a pending read; the read waits for the FIFO to be empty.
- Reset values:
  - All outputs are 0: busy_b, data, lcd_e, lcd_rs, lcd_rnw, lcd_db_o, lcd_db_oe.
  - FIFO is empty, engine is IDLE, any pending request is dropped.
- Reset asserted mid-cycle clears lcd_e asynchronously. Queued entries are lost.

## Timing
- Write or status/control access decoded in cycle N with the FIFO not full: ack at N+1.
- Entry pushed at N+1 with an idle engine: SETUP entered at S=N+2, with the pins valid from S.
- lcd_e is high from S+T_SETUP+1 through S+T_SETUP+T_ENABLE+1.
- The engine is IDLE again at S+T_SETUP+T_ENABLE+T_HOLD+3.
- Back-to-back entries: exactly one IDLE cycle between HOLD and the next SETUP.
- Sample cycle: S+T_SETUP+1+(T_ENABLE−SAMPLE_AT).
- LCD read ack: in the first IDLE cycle after HOLD.

## Test plan
- Defaults, DB_WIDTH=4: write 0x28 to addr 0 at N → ack at N+1. SETUP at N+2 with rs=0, db_o=0x8, oe=1. lcd_e high for cycles N+63..N+153. IDLE at N+195.
- Six writes back-to-back (each issued after the previous ack) → writes 1–5 ack at 1 cycle each. Write 6 stalls until the first pop frees a slot. The LCD sees all six values in order with a one-cycle IDLE gap between cycles.
- lcd_db_i=0xA, read addr 4 (rs=1) after two queued writes → the read cycle starts only after both drain. rnw=1, oe=0. Ack data 0x0000000A.
- Three queued writes, then a status read → ack data has bit 18=1, bit 16=0, level=2. A control write of 1 follows → level 0 and no further lcd_e pulses after the current cycle.
- DB_WIDTH=8, T_SETUP=T_ENABLE=T_HOLD=2, SAMPLE_AT=0: write 0xA5 to addr 4 → db_o=0xA5, rs=1, lcd_e high for exactly 3 cycles, 9-cycle engine period.
- Assert rst_b=0 during ENABLE with two entries queued → lcd_e falls with no clock edge. After release, all outputs are 0, status reads empty, and no further LCD cycles occur.
